// File: rtl/uart_word_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_word_rx
//  Description : 8N1 serial receiver. Pairs bytes (low first) into 16-bit
//                words for the CPU serial input port. Each word is held until
//                the CPU acknowledges it. Reports framing errors and overruns.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RxD,
    input  logic        ReadAck,
    output logic        serialValid,
    output logic [15:0] serialRead,
    output logic        FrameError,
    output logic        Overrun
);

    localparam int c_BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int c_TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_TO_W     = $clog2(c_TO_LIMIT + 1);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_HALF = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(c_TO_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                r_rxMeta;
    logic                r_rxS;
    logic                r_rxPrev;
    state_t              r_state;
    logic [c_BAUD_W-1:0] r_baudCnt;
    logic [2:0]          r_bitIdx;
    logic [7:0]          r_shift;
    logic [7:0]          r_lowByte;
    logic                r_phaseHigh;
    logic [c_TO_W-1:0]   r_timeoutCnt;

    logic w_startEdge;
    logic w_bitEnd;

    assign w_startEdge = r_rxPrev & ~r_rxS;
    assign w_bitEnd    = (r_baudCnt == c_BAUD_LAST);

    // Two-flop synchronizer on the asynchronous line plus one history flop for edge detection.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= RxD;
            r_rxS    <= r_rxMeta;
            r_rxPrev <= r_rxS;
        end
    end

    // Framing FSM, byte pairing, low-byte timeout and CPU handshake.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_baudCnt    <= '0;
            r_bitIdx     <= '0;
            r_shift      <= '0;
            r_lowByte    <= '0;
            r_phaseHigh  <= 1'b0;
            r_timeoutCnt <= '0;
            serialValid  <= 1'b0;
            serialRead   <= 16'h0000;
            FrameError   <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            FrameError <= 1'b0;

            // An acknowledge only matters while a word is held; a same-cycle
            // word completion below re-asserts serialValid.
            if (ReadAck && serialValid) begin
                serialValid <= 1'b0;
            end

            // Low-byte timeout: runs only while waiting in IDLE for the high byte.
            if (!r_phaseHigh) begin
                r_timeoutCnt <= '0;
            end else if (r_state == IDLE) begin
                if (r_timeoutCnt == c_TO_LAST) begin
                    r_phaseHigh  <= 1'b0;
                    r_timeoutCnt <= '0;
                end else begin
                    r_timeoutCnt <= r_timeoutCnt + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_startEdge) begin
                        r_state   <= START;
                        r_baudCnt <= '0;
                    end
                end

                START: begin
                    if (r_baudCnt == c_BAUD_HALF) begin
                        r_baudCnt <= '0;
                        r_bitIdx  <= '0;
                        // A line already back high at mid start bit was a glitch.
                        r_state   <= r_rxS ? IDLE : DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        r_shift   <= {r_rxS, r_shift[7:1]};
                        r_bitIdx  <= r_bitIdx + 1'b1;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                STOP: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        // Leave at mid stop bit so a back-to-back start edge is seen.
                        r_state   <= IDLE;
                        if (!r_rxS) begin
                            FrameError  <= 1'b1;
                            r_phaseHigh <= 1'b0;
                        end else if (!r_phaseHigh) begin
                            r_lowByte    <= r_shift;
                            r_phaseHigh  <= 1'b1;
                            r_timeoutCnt <= '0;
                        end else begin
                            r_phaseHigh <= 1'b0;
                            if (!serialValid || ReadAck) begin
                                serialRead  <= {r_shift, r_lowByte};
                                serialValid <= 1'b1;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_rx
//  Description : Self-checking bench for uart_word_rx. Directed scenarios and
//                randomized byte streams compared against a word-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int CPB   = 8;
    localparam int TOB   = 20;
    localparam int LIMIT = CPB * TOB;

    logic        Clock   = 1'b0;
    logic        Reset   = 1'b0;
    logic        RxD     = 1'b1;
    logic        ReadAck = 1'b0;
    logic        serialValid;
    logic [15:0] serialRead;
    logic        FrameError;
    logic        Overrun;

    int testCount = 0;
    int failCount = 0;
    int feCount   = 0;

    // Reference model state: what the CPU should see, in word terms.
    logic        mValid;
    logic [15:0] mWord;
    logic        mOverrun;
    logic        mPhaseHigh;
    logic [7:0]  mLow;
    int          mFe;

    uart_word_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RxD        (RxD),
        .ReadAck    (ReadAck),
        .serialValid(serialValid),
        .serialRead (serialRead),
        .FrameError (FrameError),
        .Overrun    (Overrun)
    );

    always #5 Clock = ~Clock;

    // Count FrameError cycles away from the active edge.
    always @(negedge Clock) begin
        if (Reset && FrameError === 1'b1) feCount++;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic modelReset();
        mValid     = 1'b0;
        mWord      = 16'h0000;
        mOverrun   = 1'b0;
        mPhaseHigh = 1'b0;
        mLow       = 8'h00;
        mFe        = feCount;
    endtask

    task automatic modelAck();
        mValid = 1'b0;
    endtask

    task automatic modelByte(input logic [7:0] b, input logic good, input logic timedOut,
                             input logic ackSame);
        if (timedOut) mPhaseHigh = 1'b0;
        if (!good) begin
            mFe++;
            mPhaseHigh = 1'b0;
        end else if (!mPhaseHigh) begin
            mLow       = b;
            mPhaseHigh = 1'b1;
        end else begin
            mPhaseHigh = 1'b0;
            if (!mValid || ackSame) begin
                mWord  = {b, mLow};
                mValid = 1'b1;
            end else begin
                mOverrun = 1'b1;
            end
        end
    endtask

    // One 8N1 frame; optionally pulse ReadAck in the stop-sample cycle.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic ackAtStop);
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            tick(CPB);
        end
        RxD = stopBit;
        if (ackAtStop) begin
            tick(CPB - 2);
            ReadAck = 1'b1;
            tick(1);
            ReadAck = 1'b0;
            tick(1);
        end else begin
            tick(CPB);
        end
        RxD = 1'b1;
    endtask

    task automatic pulseAck();
        ReadAck = 1'b1;
        tick(1);
        ReadAck = 1'b0;
        modelAck();
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, ".valid"},   32'(serialValid), 32'(mValid));
        checkVal({tag, ".word"},    32'(serialRead),  32'(mWord));
        checkVal({tag, ".overrun"}, 32'(Overrun),     32'(mOverrun));
        checkVal({tag, ".ferr"},    32'(feCount),     32'(mFe));
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        logic       doAck;
        int         gapKind;
        int         gap;

        Reset = 1'b0;
        tick(3);
        modelReset();
        checkAll("reset");
        checkVal("reset.frameErrorPin", 32'(FrameError), 32'd0);
        Reset = 1'b1;
        tick(20);

        // Back-to-back pair.
        sendFrame(8'h34, 1'b1, 1'b0);
        modelByte(8'h34, 1'b1, 1'b0, 1'b0);
        checkVal("pair1.lowOnly.valid", 32'(serialValid), 32'd0);
        sendFrame(8'h12, 1'b1, 1'b0);
        modelByte(8'h12, 1'b1, 1'b0, 1'b0);
        checkAll("pair1");
        checkVal("pair1.exact", 32'(serialRead), 32'h1234);

        // Overrun while holding a word.
        tick(5);
        sendFrame(8'hCD, 1'b1, 1'b0);
        modelByte(8'hCD, 1'b1, 1'b0, 1'b0);
        sendFrame(8'hAB, 1'b1, 1'b0);
        modelByte(8'hAB, 1'b1, 1'b0, 1'b0);
        checkAll("overrun");
        tick(3);
        pulseAck();
        tick(2);
        checkAll("overrun.ack");

        // Framing error, then a good pair.
        sendFrame(8'h55, 1'b0, 1'b0);
        modelByte(8'h55, 1'b0, 1'b0, 1'b0);
        tick(2 * CPB);
        checkAll("ferr");
        sendFrame(8'hEF, 1'b1, 1'b0);
        modelByte(8'hEF, 1'b1, 1'b0, 1'b0);
        sendFrame(8'hBE, 1'b1, 1'b0);
        modelByte(8'hBE, 1'b1, 1'b0, 1'b0);
        checkAll("ferr.next");
        pulseAck();

        // Short glitch while idle.
        RxD = 1'b0;
        tick(2);
        RxD = 1'b1;
        tick(30);
        checkAll("glitch");
        sendFrame(8'h01, 1'b1, 1'b0);
        modelByte(8'h01, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h00, 1'b1, 1'b0);
        modelByte(8'h00, 1'b1, 1'b0, 1'b0);
        checkAll("glitch.next");
        pulseAck();

        // Low byte timeout.
        sendFrame(8'h77, 1'b1, 1'b0);
        modelByte(8'h77, 1'b1, 1'b0, 1'b0);
        tick(LIMIT + 40);
        sendFrame(8'h22, 1'b1, 1'b0);
        modelByte(8'h22, 1'b1, 1'b1, 1'b0);
        sendFrame(8'h11, 1'b1, 1'b0);
        modelByte(8'h11, 1'b1, 1'b0, 1'b0);
        checkAll("timeout");

        // Reset in the middle of the high byte's data bits.
        sendFrame(8'hA5, 1'b1, 1'b0);
        RxD = 1'b0;
        tick(CPB);
        RxD = 1'b1;
        tick(CPB);
        RxD = 1'b0;
        tick(CPB + 3);
        RxD   = 1'b1;
        Reset = 1'b0;
        tick(1);
        modelReset();
        checkAll("midReset");
        Reset = 1'b1;
        tick(100);
        checkAll("midReset.idle");
        sendFrame(8'h78, 1'b1, 1'b0);
        modelByte(8'h78, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h56, 1'b1, 1'b0);
        modelByte(8'h56, 1'b1, 1'b0, 1'b0);
        checkAll("midReset.next");

        // Acknowledge coinciding with the completion of the next word.
        sendFrame(8'h9A, 1'b1, 1'b0);
        modelByte(8'h9A, 1'b1, 1'b0, 1'b0);
        sendFrame(8'hBC, 1'b1, 1'b1);
        modelByte(8'hBC, 1'b1, 1'b0, 1'b1);
        checkAll("ackSame");

        // Randomized byte stream.
        for (int k = 0; k < 40; k++) begin
            gapKind = int'($urandom_range(0, 5));
            gap     = (gapKind == 0) ? (LIMIT + 30) : int'($urandom_range(0, 40));
            doAck   = ($urandom_range(0, 2) == 0);
            good    = ($urandom_range(0, 7) != 0);
            b       = 8'($urandom);
            if (doAck) pulseAck();
            tick(gap);
            sendFrame(b, good, 1'b0);
            modelByte(b, good, (gapKind == 0), 1'b0);
            if (!good) tick(2 * CPB);
            checkAll($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #2000000;
        failCount++;
        $display("FAIL timeout: observed no completion, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
